// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: controller states,
// statistics counter width and a saturating-increment helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        HALT   = 2'd2
    } state_e;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_watchdog.sv
// Freeze watchdog: counts consecutive data-memory wait cycles and raises a
// sticky timeout once WAIT_MAX of them have completed. Cleared only by reset.
module freeze_watchdog #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_wait,
    output logic trip,
    output logic timeout
);

    logic [CNT_W-1:0] cnt;

    // The edge that closes the WAIT_MAX-th consecutive wait cycle trips;
    // the counter then sits at WAIT_MAX, so it can never wrap.
    assign trip = mem_wait & ~timeout & (cnt == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            if (trip)
                timeout <= 1'b1;
            if (!mem_wait)
                cnt <= '0;
            else if (!timeout)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central stall/flush controller: resolves memory freeze, EX branch flush and
// load-use bubbles onto the pipeline enables. Optional stats: HAZARD_STATS_EN.
module pipeline_hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             back_en,
    output logic             err_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loaduse,
    output logic [STAT_W-1:0] stat_flush,
    output logic [STAT_W-1:0] stat_freeze
`endif
);

    state_e state, state_nxt;
    logic   wd_trip;
    logic   load_use;
    logic   act_freeze, act_flush, act_loaduse;

    freeze_watchdog #(
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_wait(mem_wait),
        .trip    (wd_trip),
        .timeout (err_timeout)
    );

    // Register 0 is hardwired, so a load targeting it never stalls.
    assign load_use = ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN, FREEZE: begin
                if (wd_trip)
                    state_nxt = HALT;
                else if (mem_wait)
                    state_nxt = FREEZE;
                else
                    state_nxt = RUN;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        act_freeze  = (state == HALT) | mem_wait;
        act_flush   = ~act_freeze & ex_branch_taken;
        act_loaduse = ~act_freeze & ~ex_branch_taken & load_use;

        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        back_en     = 1'b1;

        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            back_en     = 1'b0;
        end else if (act_freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            back_en     = 1'b0;
        end else if (act_flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (act_loaduse) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loaduse <= '0;
            stat_flush   <= '0;
            stat_freeze  <= '0;
        end else begin
            if (act_loaduse)
                stat_loaduse <= sat_inc(stat_loaduse);
            if (act_flush)
                stat_flush <= sat_inc(stat_flush);
            if (act_freeze)
                stat_freeze <= sat_inc(stat_freeze);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Scoreboard bench for pipeline_hazard_sequencer with WAIT_MAX=4: directed
// vectors push expected control vectors, a negedge monitor pops and compares.
module tb_pipeline_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, ex_branch_taken, mem_wait;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, back_en, err_timeout;

    pipeline_hazard_sequencer #(
        .REG_W   (5),
        .WAIT_MAX(4),
        .CNT_W   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_rt          (ex_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_wait       (mem_wait),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .back_en        (back_en),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, back_en, err_timeout}
    localparam logic [5:0] RST  = 6'b001100;
    localparam logic [5:0] NORM = 6'b110010;
    localparam logic [5:0] LU   = 6'b000110;
    localparam logic [5:0] FLU  = 6'b111110;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] HLT  = 6'b000001;

    logic [5:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         passed = 0;

    wire [5:0] obs = {pc_write, ifid_write, ifid_flush, idex_bubble, back_en, err_timeout};

    always @(negedge clk) begin
        logic [5:0] e;
        string      n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (obs === e)
                passed++;
            else
                $display("FAIL %s: got %b expected %b", n, obs, e);
        end
    end

    task automatic step(input logic rn, input logic mw, input logic br, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [5:0] e, input string n);
        @(posedge clk);
        #1;
        rst_n           = rn;
        mem_wait        = mw;
        ex_branch_taken = br;
        ex_mem_read     = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_rt           = rt;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        rst_n = 1'b0; mem_wait = 1'b0; ex_branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0;

        step(0, 0, 0, 0, 0, 0, 0, RST,  "reset0");
        step(0, 0, 0, 0, 0, 0, 0, RST,  "reset1");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "normal");

        step(1, 0, 0, 1, 5, 5, 1, LU,   "loaduse_rs");
        step(1, 0, 0, 0, 5, 5, 1, NORM, "after_loaduse");
        step(1, 0, 0, 1, 7, 3, 7, LU,   "loaduse_rt");
        step(1, 0, 0, 1, 6, 5, 4, NORM, "load_no_match");
        step(1, 0, 0, 1, 0, 0, 0, NORM, "reg_zero");

        step(1, 0, 1, 1, 5, 5, 0, FLU,  "branch_over_loaduse");
        step(1, 0, 1, 0, 0, 0, 0, FLU,  "branch_only");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "after_branch");

        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 0, 0, 0, 0, FRZ, "wait_with_branch");
        step(1, 0, 1, 0, 0, 0, 0, FLU,  "held_branch_flush");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "after_held_branch");

        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 1, 9, 9, 2, FRZ, "wait_with_loaduse");
        step(1, 0, 0, 1, 9, 9, 2, LU,   "loaduse_after_wait");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "normal2");

        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 0, 0, 0, FRZ, "wait_before_timeout");
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 0, 0, 0, 0, HLT, "timeout_halt");
        step(1, 0, 1, 0, 0, 0, 0, HLT,  "halt_ignores_branch");
        step(1, 0, 0, 1, 3, 3, 0, HLT,  "halt_ignores_loaduse");
        step(1, 0, 0, 0, 0, 0, 0, HLT,  "halt_idle");

        step(0, 0, 0, 0, 0, 0, 0, RST,  "reset_from_halt");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "run_after_halt_reset");

        step(1, 1, 0, 0, 0, 0, 0, FRZ,  "freeze_a");
        step(1, 1, 0, 0, 0, 0, 0, FRZ,  "freeze_b");
        step(0, 1, 0, 0, 0, 0, 0, RST,  "reset_mid_freeze");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "run_after_freeze_reset");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 0, 0, 0, FRZ, "counter_cleared_by_reset");
        step(1, 0, 0, 0, 0, 0, 0, NORM, "final_normal");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0)
            passed++;
        else
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
